iq_sample_pacer: RTL and testbench
==================================

IQ_SAMPLE_PACER -- requirements
Module: iq_sample_pacer

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16, meaning the width of each of I and Q in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the sample buffer depth; it is a power of 2 and at least 4.
REQ-003 SHALL have parameter PREFILL, default 4, meaning the FIFO level required to start pacing; valid range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter ZERO_FILL, default 1, meaning: 1 = emit a zero sample on underrun, 0 = suppress the strobe on underrun.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: pacing enable.
REQ-008 SHALL have port restart, input, 1 bit: one-cycle pulse that flushes the FIFO and clears counters and flags.
REQ-009 SHALL have port clk_div, input, 8 bits: strobe period minus 1, in clocks (4 gives 100 MHz / 20 MSPS; 9 gives 200 MHz).
REQ-010 SHALL have port num_sample, input, 32 bits: output sample limit; 0 means unlimited.
REQ-011 SHALL have port s_i, input, IQ_WIDTH: upstream I.
REQ-012 SHALL have port s_q, input, IQ_WIDTH: upstream Q.
REQ-013 SHALL have port s_valid, input, 1 bit: upstream data valid.
REQ-014 SHALL have port s_ready, output, 1 bit: FIFO can accept; a transfer occurs when s_valid and s_ready are both high.
REQ-015 SHALL have port sample_in, output, 2*IQ_WIDTH: {I, Q}, with I in the upper half.
REQ-016 SHALL have port sample_in_strobe, output, 1 bit: one-cycle sample-valid pulse.
REQ-017 SHALL have port sample_count, output, 32 bits: number of strobes issued since reset or restart.
REQ-018 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-019 SHALL have port underrun, output, 1 bit: sticky flag set when a pacing slot found the FIFO empty.
REQ-020 SHALL have port done, output, 1 bit: high while the state is DONE.

Function
REQ-021 SHALL implement states IDLE, RUN and DONE.
REQ-022 SHALL leave IDLE for RUN on the cycle after enable=1 and fifo_level>=PREFILL.
REQ-023 SHALL return from RUN to IDLE on the cycle after enable=0; FIFO contents, sample_count and underrun are retained.
REQ-024 SHALL go from RUN to DONE on the cycle after the strobe that makes sample_count equal num_sample, when num_sample!=0.
REQ-025 SHALL leave DONE only on reset or restart; enable has no effect in DONE.
REQ-026 SHALL clear the phase counter to 0 on entry to RUN; the counter increments each cycle and wraps to 0 when it equals clk_div.
REQ-027 SHALL treat each cycle with counter==clk_div in RUN as a pacing slot; clk_div=0 makes every RUN cycle a slot.
REQ-028 SHALL latch clk_div at entry to RUN and at each wrap; a mid-period change takes effect from the next period.
REQ-029 SHALL, in a pacing slot with the FIFO non-empty, pop the head entry and assert sample_in_strobe with sample_in = the popped entry on the next cycle.
REQ-030 SHALL place the first strobe clk_div+1 cycles after the first RUN cycle.
REQ-031 SHALL, in a pacing slot with the FIFO empty: set underrun; with ZERO_FILL=1 strobe with sample_in=0; with ZERO_FILL=0 issue no strobe.
REQ-032 SHALL increment sample_count by 1 per strobe, with no saturation (wrap at 2^32).
REQ-033 SHALL hold sample_in between strobes and keep sample_in_strobe high for exactly 1 cycle per slot.
REQ-034 SHALL drive s_ready = (fifo_level < FIFO_DEPTH) in every state, including DONE.
REQ-035 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and preserve order; pointers wrap modulo FIFO_DEPTH.
REQ-036 SHALL never push when full or pop when empty.
REQ-037 SHALL, on restart, act like reset except that parameters are unaffected; restart during a slot discards that slot's strobe.
REQ-038 SHALL give reset priority over restart, and restart priority over all other events.

Reset
REQ-039 SHALL, on reset, set state=IDLE, counter=0, the FIFO empty (fifo_level=0), sample_in=0, sample_in_strobe=0, sample_count=0, underrun=0 and done=0.
REQ-040 SHALL drive s_ready=1 on the cycle after reset deasserts.

Verification
REQ-041 Bench SHALL cover: clk_div=4, 8 samples pushed, enable=1 -> strobes every 5 cycles with data in push order, sample_count=8.
REQ-042 Bench SHALL cover: num_sample=3 with 10 samples queued -> exactly 3 strobes, done=1, fifo_level=7, no further strobes.
REQ-043 Bench SHALL cover: upstream stalls after 5 samples, ZERO_FILL=1 -> 6th strobe has sample_in=0, underrun=1, cadence unchanged.
REQ-044 Bench SHALL cover: s_valid held high with no pacing -> fifo_level=FIFO_DEPTH, s_ready=0, no data lost once pacing starts.
REQ-045 Bench SHALL cover: clk_div changed 4->9 mid-period -> current period ends at 5 cycles, subsequent strobe spacing is 10 cycles.
REQ-046 Bench SHALL cover: restart asserted mid-RUN on a slot cycle -> no strobe next cycle, state=IDLE, fifo_level=0, sample_count=0, underrun=0.

Source files
------------

// File: rtl/iq_sample_pacer.sv
// iq_sample_pacer: buffers upstream I/Q samples in a small FIFO and releases
// them as single-cycle strobes at a programmable, fixed cadence.
module iq_sample_pacer #(
    parameter int IQ_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 4,
    parameter int ZERO_FILL  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          restart,
    input  logic [7:0]                    clk_div,
    input  logic [31:0]                   num_sample,
    input  logic [IQ_WIDTH-1:0]           s_i,
    input  logic [IQ_WIDTH-1:0]           s_q,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [2*IQ_WIDTH-1:0]         sample_in,
    output logic                          sample_in_strobe,
    output logic [31:0]                   sample_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 2 * IQ_WIDTH;
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [7:0]      div_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [DW-1:0]   sample_q;
    logic            strobe_q;
    logic [31:0]     count_q;
    logic            underrun_q;
    logic [DW-1:0]   mem [FIFO_DEPTH];

    logic            can_push;
    logic            push;
    logic            pop;
    logic            slot;
    logic            done_hit;

    // Handshake, pacing-slot and sample-limit decode
    always_comb begin
        can_push = (level_q < DEPTH_L);
        push     = s_valid && can_push && !reset && !restart;
        // Limit reached on the strobe cycle: leave RUN and do not start a
        // new slot, so clk_div=0 cannot squeeze in an extra strobe.
        done_hit = (state_q == RUN) && strobe_q && (num_sample != '0) &&
                   (count_q == num_sample);
        slot     = (state_q == RUN) && !done_hit && (cnt_q == div_q);
        pop      = slot && (level_q != '0);
    end

    // Sample storage; written only on an accepted upstream transfer
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {s_i, s_q};
        end
    end

    // Pacing FSM, phase counter, FIFO pointers and output registers
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            count_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            level_q  <= level_q + LW'(push) - LW'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (enable && (level_q >= PREFILL_L)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        div_q   <= clk_div;
                    end
                end
                RUN: begin
                    if (done_hit) begin
                        state_q <= DONE;
                    end else begin
                        if (!enable) begin
                            state_q <= IDLE;
                        end
                        if (slot) begin
                            cnt_q <= '0;
                            div_q <= clk_div;
                            if (pop) begin
                                strobe_q <= 1'b1;
                                sample_q <= mem[rd_ptr_q];
                                count_q  <= count_q + 32'd1;
                            end else begin
                                underrun_q <= 1'b1;
                                if (ZERO_FILL != 0) begin
                                    strobe_q <= 1'b1;
                                    sample_q <= '0;
                                    count_q  <= count_q + 32'd1;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready          = can_push;
    assign sample_in        = sample_q;
    assign sample_in_strobe = strobe_q;
    assign sample_count     = count_q;
    assign fifo_level       = level_q;
    assign underrun         = underrun_q;
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_iq_sample_pacer.sv
// Bench for iq_sample_pacer: random sample data, strobe times predicted
// arithmetically from the run start cycle and the programmed period.
module tb_iq_sample_pacer;

    localparam int IQW   = 16;
    localparam int DEPTH = 16;
    localparam int PREF  = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             restart;
    logic [7:0]       clk_div;
    logic [31:0]      num_sample;
    logic [IQW-1:0]   s_i;
    logic [IQW-1:0]   s_q;
    logic             s_valid;
    logic             s_ready;
    logic [2*IQW-1:0] sample_in;
    logic             sample_in_strobe;
    logic [31:0]      sample_count;
    logic [4:0]       fifo_level;
    logic             underrun;
    logic             done;

    int               total = 0;
    int               bad   = 0;
    int unsigned      cyc   = 0;
    int unsigned      c0;
    int unsigned      acc;
    int               nstrobe;
    int               rd;
    int               rn;
    logic [31:0]      model_q [$];
    int unsigned      exp_t [$];
    logic [31:0]      exp_d [$];
    logic [31:0]      last_data;

    iq_sample_pacer #(
        .IQ_WIDTH   (IQW),
        .FIFO_DEPTH (DEPTH),
        .PREFILL    (PREF),
        .ZERO_FILL  (1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .restart          (restart),
        .clk_div          (clk_div),
        .num_sample       (num_sample),
        .s_i              (s_i),
        .s_q              (s_q),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .sample_in        (sample_in),
        .sample_in_strobe (sample_in_strobe),
        .sample_count     (sample_count),
        .fifo_level       (fifo_level),
        .underrun         (underrun),
        .done             (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        model_q.delete();
        last_data = '0;
    endtask

    // Push n random samples back to back with pacing off
    task automatic push_n(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            s_i = w[31:16];
            s_q = w[15:0];
            s_valid = 1'b1;
            model_q.push_back(w);
            step(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic start_run(input int d);
        clk_div = 8'(d);
        enable  = 1'b1;
        c0      = cyc;
    endtask

    // Strobe k of a run lands (d+1) cycles apart, first one d+2 after enable
    task automatic plan(input int k0, input int k1, input int d);
        for (int k = k0; k < k1; k++) begin
            exp_t.push_back(c0 + 2 + d + k * (d + 1));
            exp_d.push_back(model_q.size() > 0 ? model_q.pop_front() : 32'h0);
        end
    endtask

    task automatic expect_run(input string tag);
        int extra;
        int unsigned t;
        logic [31:0] dv;
        extra = 0;
        while (exp_t.size() > 0) begin
            t  = exp_t.pop_front();
            dv = exp_d.pop_front();
            while (cyc < t) begin
                step(1);
                if (cyc < t && (sample_in_strobe !== 1'b0 || sample_in !== last_data)) extra++;
            end
            check({tag, "_strobe"}, sample_in_strobe, 1'b1);
            check({tag, "_data"}, sample_in, dv);
            last_data = dv;
        end
        check({tag, "_between"}, extra, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; restart = 1'b0; clk_div = '0; num_sample = '0;
        s_i = '0; s_q = '0; s_valid = 1'b0; last_data = '0;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_ready", s_ready, 1'b1);
        check("rst_level", fifo_level, 0);
        check("rst_strobe", sample_in_strobe, 1'b0);
        check("rst_data", sample_in, 0);
        check("rst_count", sample_count, 0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_done", done, 1'b0);

        // Basic cadence: 8 samples at clk_div=4
        push_n(8);
        check("r041_level", fifo_level, 8);
        start_run(4);
        plan(0, 8, 4);
        expect_run("r041");
        check("r041_count", sample_count, 8);
        check("r041_underrun", underrun, 1'b0);
        enable = 1'b0;
        step(2);
        do_restart();

        // Underrun with zero fill after 5 samples
        push_n(5);
        start_run(4);
        plan(0, 5, 4);
        expect_run("r043a");
        check("r043_underrun_pre", underrun, 1'b0);
        plan(5, 6, 4);
        expect_run("r043b");
        check("r043_underrun", underrun, 1'b1);
        check("r043_count", sample_count, 6);
        enable = 1'b0;
        step(2);
        do_restart();

        // Sample limit of 3 with 10 queued, clk_div=0
        push_n(10);
        num_sample = 32'd3;
        start_run(0);
        plan(0, 3, 0);
        expect_run("r042");
        step(1);
        check("r042_done", done, 1'b1);
        check("r042_level", fifo_level, 7);
        check("r042_count", sample_count, 3);
        nstrobe = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) enable = 1'b0;
            step(1);
            if (sample_in_strobe) nstrobe++;
        end
        check("r042_nostrobe", nstrobe, 0);
        check("r042_done_held", done, 1'b1);
        check("r042_level_held", fifo_level, 7);
        num_sample = '0;
        do_restart();
        check("restart_done", done, 1'b0);
        check("restart_level", fifo_level, 0);

        // Backpressure: s_valid held high until full
        acc = 0;
        for (int i = 0; i < DEPTH + 5; i++) begin
            logic [31:0] w;
            w = $urandom;
            s_i = w[31:16];
            s_q = w[15:0];
            s_valid = 1'b1;
            if (acc < DEPTH) begin
                model_q.push_back(w);
                acc++;
            end
            step(1);
        end
        s_valid = 1'b0;
        check("r044_level", fifo_level, DEPTH);
        check("r044_ready", s_ready, 1'b0);
        start_run(1);
        plan(0, DEPTH, 1);
        expect_run("r044");
        enable = 1'b0;
        check("r044_count", sample_count, DEPTH);
        check("r044_ready_after", s_ready, 1'b1);
        step(2);
        do_restart();

        // Period change 4 -> 9 in the middle of the second period
        push_n(6);
        start_run(4);
        exp_t.push_back(c0 + 6);
        exp_d.push_back(model_q.pop_front());
        expect_run("r045a");
        step(1);
        clk_div = 8'd9;
        exp_t.push_back(c0 + 11); exp_d.push_back(model_q.pop_front());
        exp_t.push_back(c0 + 21); exp_d.push_back(model_q.pop_front());
        exp_t.push_back(c0 + 31); exp_d.push_back(model_q.pop_front());
        expect_run("r045b");
        enable = 1'b0;
        step(2);
        do_restart();

        // Restart landing on a pacing slot
        push_n(4);
        start_run(3);
        plan(0, 5, 3);
        expect_run("r046_pre");
        check("r046_underrun_pre", underrun, 1'b1);
        check("r046_count_pre", sample_count, 5);
        while (cyc < c0 + 24) step(1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("r046_strobe", sample_in_strobe, 1'b0);
        check("r046_level", fifo_level, 0);
        check("r046_count", sample_count, 0);
        check("r046_underrun", underrun, 1'b0);
        nstrobe = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (sample_in_strobe) nstrobe++;
        end
        check("r046_idle", nstrobe, 0);
        enable = 1'b0;
        model_q.delete();
        last_data = '0;
        step(1);

        // Random periods and lengths, each ending in DONE via the limit
        for (int it = 0; it < 3; it++) begin
            rd = $urandom_range(0, 7);
            rn = $urandom_range(PREF, 12);
            push_n(rn);
            num_sample = 32'(rn);
            start_run(rd);
            plan(0, rn, rd);
            expect_run("rand");
            step(1);
            check("rand_done", done, 1'b1);
            check("rand_count", sample_count, rn);
            check("rand_level", fifo_level, 0);
            check("rand_underrun", underrun, 1'b0);
            enable = 1'b0;
            num_sample = '0;
            do_restart();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
